// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the keyboard action scanner: sizes, action indices,
// the power-up action-to-keycode map, special USB keycodes, the scanner FSM
// state type and a rollover detector for a full report.
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int N_ACTIONS = 10;
  localparam int N_SLOTS   = 6;
  localparam int IDX_W     = $clog2(N_ACTIONS);

  // Action order matches the held/pressed/released bit positions.
  typedef enum logic [IDX_W-1:0] {
    P1_UP    = 4'd0,
    P1_DOWN  = 4'd1,
    P1_LEFT  = 4'd2,
    P1_RIGHT = 4'd3,
    P1_FIRE  = 4'd4,
    P2_UP    = 4'd5,
    P2_DOWN  = 4'd6,
    P2_LEFT  = 4'd7,
    P2_RIGHT = 4'd8,
    P2_FIRE  = 4'd9
  } action_e;

  localparam logic [7:0] KC_NONE     = 8'h00;
  localparam logic [7:0] KC_ROLLOVER = 8'h01;

  // Entry 0 is the rightmost byte: P1 W,S,A,D,Space then P2 arrows, Enter.
  localparam logic [N_ACTIONS-1:0][7:0] DEFAULT_MAP = {
    8'h28, 8'h4F, 8'h50, 8'h51, 8'h52,
    8'h2C, 8'h07, 8'h04, 8'h16, 8'h1A
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } scan_state_t;

  // A keyboard that overflows its 6 slots fills them with ErrorRollOver;
  // one such slot is enough to treat the whole report as unusable.
  function automatic logic has_rollover(input logic [8*N_SLOTS-1:0] codes);
    logic found;
    found = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (codes[8*i +: 8] == KC_ROLLOVER) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/key_action_scanner_slot_match.sv
// ---------------------------------------------------------------------------
// slot_match
// Combinational compare of one target keycode against every slot of a
// report. A target of KC_NONE means "action unmapped" and never matches,
// even though empty report slots also carry 0x00.
//   i_target : keycode assigned to the action being scanned
//   i_slots  : report slots, slot i in bits [8i+7:8i]
//   o_match  : 1 when any slot equals a non-zero target
// ---------------------------------------------------------------------------
module slot_match
  import key_pkg::*;
(
  input  logic [7:0]           i_target,
  input  logic [8*N_SLOTS-1:0] i_slots,
  output logic                 o_match
);

  // Duplicate slots simply OR into the same single match bit.
  always_comb begin
    o_match = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (i_slots[8*i +: 8] == i_target) o_match = 1'b1;
    end
    if (i_target == KC_NONE) o_match = 1'b0;
  end

endmodule

// File: rtl/key_action_scanner.sv
// ---------------------------------------------------------------------------
// key_action_scanner
// Turns each USB keyboard report into held levels and one-cycle
// pressed/released pulses for the ten game actions. One slot comparator is
// shared across the actions, one action per cycle, so a report takes
// N_ACTIONS SCAN cycles plus one COMMIT cycle.
//   Clk, Reset_n            : clock, asynchronous active-low reset
//   keycodes, report_valid  : incoming report and its one-cycle strobe
//   cfg_we/cfg_idx/cfg_code : action-to-keycode map write (IDLE only)
//   cfg_ready               : map writes accepted (FSM in IDLE)
//   held/pressed/released   : per-action level and edge pulses
//   update_valid            : pulses with every COMMIT
//   rollover_err            : pulses when a report is dropped for rollover
//   busy                    : FSM in SCAN or COMMIT
// ---------------------------------------------------------------------------
module key_action_scanner
  import key_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [8*N_SLOTS-1:0] keycodes,
  input  logic                 report_valid,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [7:0]           cfg_code,
  output logic                 cfg_ready,
  output logic [N_ACTIONS-1:0] held,
  output logic [N_ACTIONS-1:0] pressed,
  output logic [N_ACTIONS-1:0] released,
  output logic                 update_valid,
  output logic                 rollover_err,
  output logic                 busy
);

  scan_state_t                 r_state;
  logic [N_ACTIONS-1:0][7:0]   r_map;
  logic [8*N_SLOTS-1:0]        r_snap;
  logic [8*N_SLOTS-1:0]        r_pend;
  logic                        r_pend_valid;
  logic [IDX_W-1:0]            r_idx;
  logic [N_ACTIONS-1:0]        r_next;

  logic                        w_match;
  logic [8*N_SLOTS-1:0]        w_idle_src;
  logic                        w_cfg_ok;

  slot_match u_slot_match (
    .i_target (r_map[r_idx]),
    .i_slots  (r_snap),
    .o_match  (w_match)
  );

  // A live report in IDLE is newer than anything left pending.
  assign w_idle_src = report_valid ? keycodes : r_pend;
  assign w_cfg_ok   = cfg_we && (cfg_idx < IDX_W'(N_ACTIONS));

  assign cfg_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);

  // Pulses default low every cycle; COMMIT and rollover raise them for one.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_map        <= DEFAULT_MAP;
      r_snap       <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_idx        <= '0;
      r_next       <= '0;
      held         <= '0;
      pressed      <= '0;
      released     <= '0;
      update_valid <= 1'b0;
      rollover_err <= 1'b0;
    end else begin
      pressed      <= '0;
      released     <= '0;
      update_valid <= 1'b0;
      rollover_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Remapping an action drops its held level silently so the old
          // key cannot leave it stuck on.
          if (w_cfg_ok) begin
            r_map[cfg_idx] <= cfg_code;
            held[cfg_idx]  <= 1'b0;
          end
          if (report_valid || r_pend_valid) begin
            r_pend_valid <= 1'b0;
            if (has_rollover(w_idle_src)) begin
              rollover_err <= 1'b1;
            end else begin
              r_snap  <= w_idle_src;
              r_idx   <= '0;
              r_next  <= '0;
              r_state <= ST_SCAN;
            end
          end
        end

        ST_SCAN: begin
          if (w_match) r_next[r_idx] <= 1'b1;
          if (report_valid) begin
            r_pend       <= keycodes;
            r_pend_valid <= 1'b1;
          end
          if (r_idx == IDX_W'(N_ACTIONS - 1)) r_state <= ST_COMMIT;
          else                                r_idx   <= r_idx + 1'b1;
        end

        ST_COMMIT: begin
          held         <= r_next;
          pressed      <= r_next & ~held;
          released     <= ~r_next & held;
          update_valid <= 1'b1;
          // Any report arriving now becomes the pending one; the previously
          // pending report (if any) is handed straight to a new SCAN.
          r_pend_valid <= report_valid;
          if (report_valid) r_pend <= keycodes;
          r_state <= ST_IDLE;
          if (r_pend_valid) begin
            if (has_rollover(r_pend)) begin
              rollover_err <= 1'b1;
            end else begin
              r_snap  <= r_pend;
              r_idx   <= '0;
              r_next  <= '0;
              r_state <= ST_SCAN;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
